// File: rtl/mu0_control_fsm.sv
// MU0 fetch/execute sequencer with a memory-ready handshake and a bus timeout.
// A timed-out access halts the core and sets a sticky Fault.
module mu0_control_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic [3:0] Opcode,
  input  logic       N,
  input  logic       Z,
  input  logic       MemReady,
  output logic [1:0] M,
  output logic       XSel,
  output logic       YSel,
  output logic       AddrSel,
  output logic       PCEn,
  output logic       IREn,
  output logic       AccEn,
  output logic       Rd,
  output logic       Wr,
  output logic       Halted,
  output logic       Fault
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          mem_op, access, expired;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    mem_op  = (Opcode[3:2] == 2'b00);
    access  = (state_q == FETCH) || ((state_q == EXEC) && mem_op);
    expired = (TIMEOUT > 0) && access && !MemReady && (cnt_q == CNT_LAST);

    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (MemReady)     state_d = EXEC;
        else if (expired) state_d = HALT;
      end
      EXEC: begin
        if (mem_op) begin
          if (MemReady)     state_d = FETCH;
          else if (expired) state_d = HALT;
        end else if (Opcode == 4'h7) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // Counting only while the same access keeps waiting; any state change or MemReady clears it.
    cnt_d = '0;
    if (access && !MemReady && (state_d == state_q))
      cnt_d = cnt_q + 1'b1;

    fault_d = fault_q | expired;
  end

  always_comb begin
    M       = 2'b00;
    XSel    = 1'b0;
    YSel    = 1'b0;
    AddrSel = 1'b0;
    PCEn    = 1'b0;
    IREn    = 1'b0;
    AccEn   = 1'b0;
    Rd      = 1'b0;
    Wr      = 1'b0;
    Halted  = 1'b0;
    Fault   = fault_q;
    if (nReset) begin
      unique case (state_q)
        FETCH: begin
          Rd   = 1'b1;
          XSel = 1'b1;
          M    = 2'b10;
          IREn = MemReady;
          PCEn = MemReady;
        end
        EXEC: begin
          unique case (Opcode)
            4'h0: begin
              AddrSel = 1'b1;
              Rd      = 1'b1;
              AccEn   = MemReady;
            end
            4'h1: begin
              AddrSel = 1'b1;
              Wr      = 1'b1;
            end
            4'h2, 4'h3: begin
              AddrSel = 1'b1;
              Rd      = 1'b1;
              M       = Opcode[0] ? 2'b11 : 2'b01;
              AccEn   = MemReady;
            end
            4'h4, 4'h5, 4'h6: begin
              YSel = 1'b1;
              PCEn = (Opcode == 4'h4) ? 1'b1 :
                     (Opcode == 4'h5) ? ~N : ~Z;
            end
            default: ;
          endcase
        end
        HALT:    Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_control_fsm.sv
// Directed bench for mu0_control_fsm: one instance with TIMEOUT=16 and one with the
// timeout disabled, both driven by the same stimulus.
module tb_mu0_control_fsm;

  logic       Clk = 1'b0;
  logic       nReset;
  logic [3:0] Opcode;
  logic       N, Z, MemReady;

  logic [1:0] M, M0;
  logic XSel, YSel, AddrSel, PCEn, IREn, AccEn, Rd, Wr, Halted, Fault;
  logic XSel0, YSel0, AddrSel0, PCEn0, IREn0, AccEn0, Rd0, Wr0, Halted0, Fault0;

  int checks = 0;
  int errors = 0;

  logic [11:0] obs, obs0;
  logic [11:0] F_RDY, F_WAIT, LDA_RDY, LDA_WAIT, ADD_RDY, STA, JMP_T, JMP_NT;
  logic [11:0] IDLE, HALTED, FAULTED;

  always #5 Clk = ~Clk;

  mu0_control_fsm #(.TIMEOUT(16)) dut (
    .Clk(Clk), .nReset(nReset), .Opcode(Opcode), .N(N), .Z(Z), .MemReady(MemReady),
    .M(M), .XSel(XSel), .YSel(YSel), .AddrSel(AddrSel), .PCEn(PCEn), .IREn(IREn),
    .AccEn(AccEn), .Rd(Rd), .Wr(Wr), .Halted(Halted), .Fault(Fault)
  );

  mu0_control_fsm #(.TIMEOUT(0)) dut0 (
    .Clk(Clk), .nReset(nReset), .Opcode(Opcode), .N(N), .Z(Z), .MemReady(MemReady),
    .M(M0), .XSel(XSel0), .YSel(YSel0), .AddrSel(AddrSel0), .PCEn(PCEn0), .IREn(IREn0),
    .AccEn(AccEn0), .Rd(Rd0), .Wr(Wr0), .Halted(Halted0), .Fault(Fault0)
  );

  assign obs  = {M, XSel, YSel, AddrSel, PCEn, IREn, AccEn, Rd, Wr, Halted, Fault};
  assign obs0 = {M0, XSel0, YSel0, AddrSel0, PCEn0, IREn0, AccEn0, Rd0, Wr0, Halted0, Fault0};

  function automatic logic [11:0] o(input logic [1:0] m, input logic xs, input logic ys,
                                    input logic as, input logic pce, input logic ire,
                                    input logic acce, input logic rd, input logic wr,
                                    input logic h, input logic f);
    return {m, xs, ys, as, pce, ire, acce, rd, wr, h, f};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where inputs are changed.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic pulse_reset();
    nReset = 1'b0;
    #1;
    chk("reset_outputs", obs, IDLE);
    chk("reset_outputs_t0", obs0, IDLE);
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //         M     XS  YS  AS  PCE IRE ACE Rd  Wr  H   F
    F_RDY    = o(2'b10, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    F_WAIT   = o(2'b10, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    LDA_RDY  = o(2'b00, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    LDA_WAIT = o(2'b00, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    ADD_RDY  = o(2'b01, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    STA      = o(2'b00, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    JMP_T    = o(2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    JMP_NT   = o(2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    IDLE     = '0;
    HALTED   = o(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    FAULTED  = o(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

    nReset = 1'b0; Opcode = 4'h0; N = 1'b0; Z = 1'b0; MemReady = 1'b1;

    // Outputs held low during reset even with MemReady asserted.
    @(negedge Clk);
    #1;
    chk("in_reset", obs, IDLE);
    chk("in_reset_t0", obs0, IDLE);
    nReset = 1'b1;

    // LDA, ADD, STA, STP with zero-wait memory.
    #1; chk("t1_fetch_lda", obs, F_RDY);
    tick(); Opcode = 4'h0; #1; chk("t1_exec_lda", obs, LDA_RDY);
    tick(); #1; chk("t1_fetch_add", obs, F_RDY);
    tick(); Opcode = 4'h2; #1; chk("t1_exec_add", obs, ADD_RDY);
    tick(); #1; chk("t1_fetch_sta", obs, F_RDY);
    tick(); Opcode = 4'h1; #1; chk("t1_exec_sta", obs, STA);
    tick(); #1; chk("t1_fetch_stp", obs, F_RDY);
    tick(); Opcode = 4'h7; #1; chk("t1_exec_stp", obs, IDLE);
    tick(); #1; chk("t1_halted", obs, HALTED);
    tick(); Opcode = 4'h0; #1; chk("t1_halt_absorbing", obs, HALTED);
    chk("t1_halted_t0", obs0, HALTED);

    // Conditional and unconditional jumps.
    tick(); pulse_reset();
    #1; chk("t2_fetch", obs, F_RDY);
    tick(); Opcode = 4'h5; N = 1'b1; #1; chk("t2_jge_n1", obs, JMP_NT);
    tick(); #1; chk("t2_fetch2", obs, F_RDY);
    tick(); Opcode = 4'h5; N = 1'b0; #1; chk("t2_jge_n0", obs, JMP_T);
    tick(); #1; chk("t2_fetch3", obs, F_RDY);
    tick(); Opcode = 4'h6; Z = 1'b1; #1; chk("t2_jne_z1", obs, JMP_NT);
    tick(); #1; chk("t2_fetch4", obs, F_RDY);
    tick(); Opcode = 4'h6; Z = 1'b0; #1; chk("t2_jne_z0", obs, JMP_T);
    tick(); #1; chk("t2_fetch5", obs, F_RDY);
    tick(); Opcode = 4'h4; Z = 1'b1; N = 1'b1; #1; chk("t2_jmp", obs, JMP_T);

    // Fetch stalled 3 cycles, then a NOP (opcode B) that ignores MemReady.
    tick(); MemReady = 1'b0; #1; chk("t3_wait1", obs, F_WAIT);
    tick(); #1; chk("t3_wait2", obs, F_WAIT);
    tick(); #1; chk("t3_wait3", obs, F_WAIT);
    tick(); MemReady = 1'b1; #1; chk("t3_ready", obs, F_RDY);
    tick(); Opcode = 4'hB; #1; chk("t6_nop", obs, IDLE);
    chk("t6_nop_t0", obs0, IDLE);
    tick(); #1; chk("t6_fetch_after_nop", obs, F_RDY);

    // LDA whose memory never answers: 16 waiting cycles, then Fault.
    tick(); Opcode = 4'h0; MemReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1; chk($sformatf("t4_lda_wait%0d", i), obs, LDA_WAIT);
      tick();
    end
    #1; chk("t4_faulted", obs, FAULTED);
    chk("t6_no_timeout_t0", obs0, LDA_WAIT);
    for (int i = 0; i < 4; i++) tick();
    #1; chk("t4_still_faulted", obs, FAULTED);
    chk("t6_still_waiting_t0", obs0, LDA_WAIT);
    tick(); MemReady = 1'b1; #1;
    chk("t4_ready_ignored_halt", obs, FAULTED);
    chk("t6_late_ready_t0", obs0, LDA_RDY);

    // Reset clears Fault; reset during a stalled STA drops Wr at once.
    tick(); pulse_reset();
    #1; chk("t5_fetch", obs, F_RDY);
    tick(); Opcode = 4'h1; MemReady = 1'b0; #1; chk("t5_sta_wait", obs, STA);
    tick(); #1; chk("t5_sta_wait2", obs, STA);
    nReset = 1'b0; #1; chk("t5_reset_mid_sta", obs, IDLE);
    @(negedge Clk); nReset = 1'b1; #1; chk("t5_post_reset_fetch", obs, F_WAIT);
    MemReady = 1'b1; #1; chk("t5_post_reset_ready", obs, F_RDY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
